// File: rtl/core_trace_checker_if.sv
// Debug writeback and golden-trace loader signals shared by Core, the
// trace loader and the trace checker.
interface core_trace_checker_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      dbg_wen;
    logic [REG_ADDR_WIDTH-1:0] dbg_waddr;
    logic [DATA_WIDTH-1:0]     dbg_wdata;
    logic [ADDR_WIDTH-1:0]     dbg_pc;
    logic                      exp_valid;
    logic                      exp_ready;
    logic [ADDR_WIDTH-1:0]     exp_pc;
    logic [REG_ADDR_WIDTH-1:0] exp_waddr;
    logic [DATA_WIDTH-1:0]     exp_wdata;

    modport master (
        output dbg_wen, dbg_waddr, dbg_wdata, dbg_pc,
        output exp_valid, exp_pc, exp_waddr, exp_wdata,
        input  exp_ready
    );

    modport slave (
        input  dbg_wen, dbg_waddr, dbg_wdata, dbg_pc,
        input  exp_valid, exp_pc, exp_waddr, exp_wdata,
        output exp_ready
    );
endinterface

// File: rtl/core_trace_checker.sv
// Self-checking monitor: buffers a golden {pc, reg addr, data} trace and
// compares every retired register write from Core against it.
module core_trace_checker #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    REG_ADDR_WIDTH = 5,
    parameter int                    TRACE_DEPTH    = 16,
    parameter logic [DATA_WIDTH-1:0] END_MAGIC      = 32'habcd0000,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          clear,
    input  logic                                          start,
    core_trace_checker_if.slave                           tif,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          pass,
    output logic [1:0]                                    err_code,
    output logic [ADDR_WIDTH+REG_ADDR_WIDTH+DATA_WIDTH-1:0] err_got,
    output logic [ADDR_WIDTH+REG_ADDR_WIDTH+DATA_WIDTH-1:0] err_exp,
    output logic [31:0]                                   wb_count,
    output logic [31:0]                                   tick_count
);
    localparam int                 PTR_W      = $clog2(TRACE_DEPTH);
    localparam int                 ENTRY_W    = ADDR_WIDTH + REG_ADDR_WIDTH + DATA_WIDTH;
    localparam logic [PTR_W:0]     DEPTH_C    = (PTR_W+1)'(TRACE_DEPTH);
    localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
    localparam logic [31:0]        IDLE_LIMIT = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]        SAT_MAX    = 32'hffff_ffff;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [ENTRY_W-1:0]   mem_r [TRACE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]       count_r, count_nxt_s;
    logic                 exp_ready_r;
    logic [31:0]          idle_r;

    logic                 retire_s, empty_s, match_s, push_s, pop_s, in_run_s;
    logic [ENTRY_W-1:0]   head_s, got_s, entry_in_s;

    assign retire_s   = tif.dbg_wen && (tif.dbg_waddr != {REG_ADDR_WIDTH{1'b0}});
    assign empty_s    = (count_r == {(PTR_W+1){1'b0}});
    assign head_s     = mem_r[rd_ptr_r];
    assign got_s      = {tif.dbg_pc, tif.dbg_waddr, tif.dbg_wdata};
    assign entry_in_s = {tif.exp_pc, tif.exp_waddr, tif.exp_wdata};
    assign match_s    = (head_s == got_s);
    assign in_run_s   = (state_r == ST_RUN);
    // Ready comes from the registered fill level, so a same-cycle pop never frees a slot early.
    assign push_s     = tif.exp_valid && exp_ready_r && !clear;
    // A mismatching head is still consumed; only an empty FIFO has nothing to pop.
    assign pop_s      = in_run_s && retire_s && !empty_s && !clear;
    assign tif.exp_ready = exp_ready_r;

    // Next fill level of the golden FIFO.
    always_comb begin
        count_nxt_s = count_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
    end

    // Verdict FSM: next state; retire outranks timeout, clear outranks everything.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (retire_s) begin
                    if (empty_s || !match_s)         state_nxt_s = ST_FAIL;
                    else if (tif.dbg_wdata == END_MAGIC) state_nxt_s = ST_PASS;
                    else                             state_nxt_s = ST_RUN;
                end else if (idle_r == IDLE_LIMIT) begin
                    state_nxt_s = ST_TIMEOUT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: state_nxt_s = state_r;
            default:                      state_nxt_s = ST_IDLE;
        endcase
        if (clear) state_nxt_s = ST_IDLE;
        else       state_nxt_s = state_nxt_s;
    end

    // Verdict FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Golden FIFO pointers, fill level and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {(PTR_W+1){1'b0}};
            exp_ready_r <= 1'b1;
        end else if (clear) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {(PTR_W+1){1'b0}};
            exp_ready_r <= 1'b1;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r     <= count_nxt_s;
            exp_ready_r <= (count_nxt_s != DEPTH_C);
        end
    end

    // Golden entry storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= entry_in_s;
    end

    // Run counters, idle timer, error capture and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0; done <= 1'b0; pass <= 1'b0;
            err_code <= 2'd0; err_got <= '0; err_exp <= '0;
            wb_count <= 32'd0; tick_count <= 32'd0; idle_r <= 32'd0;
        end else if (clear) begin
            busy <= 1'b0; done <= 1'b0; pass <= 1'b0;
            err_code <= 2'd0; err_got <= '0; err_exp <= '0;
            wb_count <= 32'd0; tick_count <= 32'd0; idle_r <= 32'd0;
        end else begin
            busy <= (state_nxt_s == ST_RUN);
            done <= (state_nxt_s == ST_PASS) || (state_nxt_s == ST_FAIL) ||
                    (state_nxt_s == ST_TIMEOUT);
            pass <= (state_nxt_s == ST_PASS);
            if (state_r == ST_IDLE && start) begin
                err_code <= 2'd0; err_got <= '0; err_exp <= '0;
                wb_count <= 32'd0; tick_count <= 32'd0; idle_r <= 32'd0;
            end else if (in_run_s) begin
                if (tick_count != SAT_MAX) tick_count <= tick_count + 32'd1;
                if (retire_s) begin
                    idle_r <= 32'd0;
                    if (empty_s) begin
                        // Nothing to compare against: report the empty head as zero.
                        err_code <= 2'd2; err_got <= got_s; err_exp <= '0;
                    end else if (!match_s) begin
                        err_code <= 2'd1; err_got <= got_s; err_exp <= head_s;
                    end else if (wb_count != SAT_MAX) begin
                        wb_count <= wb_count + 32'd1;
                    end
                end else begin
                    idle_r <= idle_r + 32'd1;
                    if (idle_r == IDLE_LIMIT) err_code <= 2'd3;
                end
            end
        end
    end
endmodule

// File: tb/tb_core_trace_checker.sv
// Randomized and directed bench for core_trace_checker against a queue-based model.
module tb_core_trace_checker;
    localparam int AW = 32, DW = 32, RW = 5, DEPTH = 16, TMO = 8;
    localparam int EW = AW + RW + DW;
    localparam logic [DW-1:0] MAGIC = 32'habcd0000;
    localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3, M_TMO = 4;

    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, start = 1'b0;
    logic busy, done, pass;
    logic [1:0] err_code;
    logic [EW-1:0] err_got, err_exp;
    logic [31:0] wb_count, tick_count;
    int n_vec = 0, n_miss = 0;

    core_trace_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)) tif();

    core_trace_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW),
                         .TRACE_DEPTH(DEPTH), .END_MAGIC(MAGIC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .tif(tif),
        .busy(busy), .done(done), .pass(pass), .err_code(err_code),
        .err_got(err_got), .err_exp(err_exp), .wb_count(wb_count), .tick_count(tick_count)
    );

    always #5 clk = ~clk;

    initial begin
        tif.dbg_wen = 1'b0; tif.dbg_waddr = '0; tif.dbg_wdata = '0; tif.dbg_pc = '0;
        tif.exp_valid = 1'b0; tif.exp_pc = '0; tif.exp_waddr = '0; tif.exp_wdata = '0;
    end

    // ---------------- behavioural model ----------------
    logic [EW-1:0] m_q[$];
    int            m_state = M_IDLE;
    logic [1:0]    m_code = 2'd0;
    logic [EW-1:0] m_got = '0, m_exp = '0, m_head, m_in;
    logic [31:0]   m_wb = 32'd0, m_tick = 32'd0;
    int            m_idle = 0;
    bit            m_push, m_ret;

    task automatic m_clear();
        m_q.delete(); m_state = M_IDLE; m_code = 2'd0; m_got = '0; m_exp = '0;
        m_wb = 32'd0; m_tick = 32'd0; m_idle = 0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) m_clear();
        else if (clear) m_clear();
        else begin
            m_push = tif.exp_valid && (m_q.size() < DEPTH);
            m_in   = {tif.exp_pc, tif.exp_waddr, tif.exp_wdata};
            m_ret  = tif.dbg_wen && (tif.dbg_waddr != 0);
            if (m_state == M_IDLE && start) begin
                m_state = M_RUN; m_wb = 0; m_tick = 0; m_idle = 0;
                m_code = 0; m_got = '0; m_exp = '0;
            end else if (m_state == M_RUN) begin
                if (m_tick != 32'hffff_ffff) m_tick = m_tick + 1;
                if (m_ret) begin
                    m_idle = 0;
                    if (m_q.size() == 0) begin
                        m_state = M_FAIL; m_code = 2;
                        m_got = {tif.dbg_pc, tif.dbg_waddr, tif.dbg_wdata}; m_exp = '0;
                    end else begin
                        m_head = m_q.pop_front();
                        if (m_head != {tif.dbg_pc, tif.dbg_waddr, tif.dbg_wdata}) begin
                            m_state = M_FAIL; m_code = 1;
                            m_got = {tif.dbg_pc, tif.dbg_waddr, tif.dbg_wdata}; m_exp = m_head;
                        end else begin
                            if (m_wb != 32'hffff_ffff) m_wb = m_wb + 1;
                            if (tif.dbg_wdata == MAGIC) m_state = M_PASS;
                        end
                    end
                end else begin
                    m_idle = m_idle + 1;
                    if (m_idle >= TMO) begin m_state = M_TMO; m_code = 3; end
                end
            end
            if (m_push) m_q.push_back(m_in);
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        chk("busy", busy, m_state == M_RUN);
        chk("done", done, m_state >= M_PASS);
        chk("pass", pass, m_state == M_PASS);
        chk("err_code", err_code, m_code);
        chk("err_got", err_got, m_got);
        chk("err_exp", err_exp, m_exp);
        chk("wb_count", wb_count, m_wb);
        chk("tick_count", tick_count, m_tick);
        chk("exp_ready", tif.exp_ready, m_q.size() < DEPTH);
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk); #1;
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic [RW-1:0] ra, input logic [DW-1:0] d);
        tif.exp_valid = 1'b1; tif.exp_pc = pc; tif.exp_waddr = ra; tif.exp_wdata = d;
        cyc(); tif.exp_valid = 1'b0;
    endtask

    task automatic retire(input logic [AW-1:0] pc, input logic [RW-1:0] ra, input logic [DW-1:0] d);
        tif.dbg_wen = 1'b1; tif.dbg_pc = pc; tif.dbg_waddr = ra; tif.dbg_wdata = d;
        cyc(); tif.dbg_wen = 1'b0;
    endtask

    task automatic do_start(); start = 1'b1; cyc(); start = 1'b0; endtask
    task automatic do_clear(); clear = 1'b1; cyc(); clear = 1'b0; endtask

    task automatic load3();
        push(32'h0, 5'd1, 32'h5); push(32'h4, 5'd2, 32'h7); push(32'h8, 5'd3, MAGIC);
    endtask

    initial begin : stim
        int n;
        cyc(); cyc();
        chk("reset_ready", tif.exp_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        rst_n = 1'b1; cyc();

        // Full trace ends on magic.
        load3(); do_start();
        retire(32'h0, 5'd1, 32'h5); retire(32'h4, 5'd2, 32'h7); retire(32'h8, 5'd3, MAGIC);
        chk("pass_flag", pass, 1'b1);
        chk("pass_wb", wb_count, 32'd3);
        chk("pass_tick", tick_count, 32'd3);
        do_clear();
        chk("clear_done", done, 1'b0);

        // Data mismatch on second retire.
        load3(); do_start();
        retire(32'h0, 5'd1, 32'h5); retire(32'h4, 5'd2, 32'h8);
        chk("mm_code", err_code, 2'd1);
        chk("mm_got", err_got[DW-1:0], 32'h8);
        chk("mm_exp", err_exp[DW-1:0], 32'h7);
        chk("mm_pass", pass, 1'b0);
        do_clear();

        // Underflow.
        do_start(); retire(32'h0, 5'd4, 32'h1);
        chk("uf_code", err_code, 2'd2);
        chk("uf_done", done, 1'b1);
        do_clear();

        // Timeout latency after the last retire.
        push(32'h0, 5'd1, 32'h5); do_start(); retire(32'h0, 5'd1, 32'h5);
        n = 0;
        while (!done && n < 20) begin cyc(); n++; end
        chk("tmo_latency", n, 8);
        chk("tmo_code", err_code, 2'd3);
        do_clear();

        // Full FIFO, r0 writes ignored, one pop frees a slot.
        for (int i = 0; i < DEPTH; i++) push(32'(i * 4), 5'((i % 31) + 1), 32'h100 + 32'(i));
        chk("full_ready", tif.exp_ready, 1'b0);
        push(32'hdead, 5'd9, 32'h9);
        do_start();
        retire(32'h0, 5'd0, 32'h123); retire(32'h0, 5'd0, 32'h456);
        chk("r0_ready", tif.exp_ready, 1'b0);
        chk("r0_wb", wb_count, 32'd0);
        retire(32'h0, 5'd1, 32'h100);
        chk("pop_ready", tif.exp_ready, 1'b1);
        chk("pop_wb", wb_count, 32'd1);
        do_clear();

        // Asynchronous reset mid-run with entries queued.
        for (int i = 0; i < 5; i++) push(32'(i), 5'd1, 32'(i));
        do_start(); cyc();
        rst_n = 1'b0; #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", tif.exp_ready, 1'b1);
        chk("rst_tick", tick_count, 32'd0);
        cyc(); rst_n = 1'b1; cyc();

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            tif.exp_valid = ($urandom_range(0, 1) == 1);
            tif.exp_pc    = $urandom;
            tif.exp_waddr = 5'($urandom_range(1, 31));
            tif.exp_wdata = ($urandom_range(0, 7) == 0) ? MAGIC : 32'($urandom);
            start = (m_state == M_IDLE) && ($urandom_range(0, 3) == 0);
            clear = ((m_state >= M_PASS) && ($urandom_range(0, 2) == 0)) ||
                    ($urandom_range(0, 199) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            tif.dbg_wen = ($urandom_range(0, 2) != 0);
            if (m_q.size() > 0 && $urandom_range(0, 9) != 0)
                {tif.dbg_pc, tif.dbg_waddr, tif.dbg_wdata} = m_q[0];
            else begin
                tif.dbg_pc = $urandom; tif.dbg_waddr = 5'($urandom); tif.dbg_wdata = $urandom;
            end
            if ($urandom_range(0, 15) == 0) tif.dbg_waddr = 5'd0;
            cyc();
        end
        tif.exp_valid = 1'b0; tif.dbg_wen = 1'b0; start = 1'b0; clear = 1'b0; rst_n = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
